rx_frame_parser: RTL and testbench

// Per-port RX stage feeding the MAC switch. Takes the de-preambled byte stream of one PHY (DST..FCS).

---
 rtl/rx_frame_parser_if.sv | 23 ++
 rtl/rx_frame_parser.sv | 143 ++++++++++++++
 tb/tb_rx_frame_parser.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_parser_if.sv
// RX byte stream plus header/body FIFO write ports of one PHY parser.
// master = PHY and switch-FIFO side, slave = the parser.
interface rx_frame_parser_if;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         rx_last;
  logic [127:0] h_fifo_din;
  logic         h_fifo_wren;
  logic         h_fifo_full;
  logic [7:0]   b_fifo_din;
  logic         b_fifo_del_in;
  logic         b_fifo_wren;
  logic         b_fifo_afull;

  modport master (
    output rx_valid, rx_data, rx_last, h_fifo_full, b_fifo_afull,
    input  h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_del_in, b_fifo_wren
  );
  modport slave (
    input  rx_valid, rx_data, rx_last, h_fifo_full, b_fifo_afull,
    output h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_del_in, b_fifo_wren
  );
endinterface

// File: rtl/rx_frame_parser.sv
// Per-PHY RX parser: splits each frame into a 128-bit header word and a delimited
// body byte stream, checks CRC-32/length and flags 802.1 control frames.
module rx_frame_parser #(
  parameter logic [1:0] PORT_ID   = 2'd0,
  parameter int         MIN_LEN   = 64,
  parameter int         MAX_LEN   = 1518,
  parameter bit         CTRL_DROP = 1'b1
) (
  input  logic               clk,
  input  logic               arst_n,
  rx_frame_parser_if.slave   bus,
  output logic [15:0]        rx_frame_cnt,
  output logic [15:0]        rx_drop_cnt
);
  localparam logic [10:0] MIN_L = MIN_LEN[10:0];
  localparam logic [10:0] MAX_L = MAX_LEN[10:0];

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_DRAIN, S_COMMIT, S_DISCARD} state_t;

  state_t        state_q;
  logic [10:0]   byte_cnt_q;
  logic [111:0]  hdr_q;
  logic          is_ctrl_q, trunc_q;
  logic [31:0]   crc_q, crc_base, crc_d;
  logic [127:0]  h_din_q;
  logic          h_wren_q, b_del_q, b_wren_q;
  logic [7:0]    b_din_q;
  logic [15:0]   frame_cnt_q, drop_cnt_q;
  logic          rx_v, idle_like, start_full, ctrl_now, crc_ok, frm_ok;
  logic [10:0]   cnt_inc;
  logic [47:0]   dst_now;
  logic [1:0]    drop_inc;

  // Non-reflected register fed LSB-first: equivalent to reflected CRC-32, residual C704DD7B.
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[30:0], 1'b0} ^ (((r[31] ^ d[i]) == 1'b1) ? 32'h04C11DB7 : 32'h0);
    return r;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign rx_v       = bus.rx_valid;
  assign idle_like  = (state_q == S_IDLE) || (state_q == S_COMMIT);
  assign start_full = bus.h_fifo_full | bus.b_fifo_afull;
  assign cnt_inc    = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign dst_now    = {hdr_q[39:0], bus.rx_data};
  assign ctrl_now   = (dst_now[47:4] == 44'h0180C200000);
  assign crc_ok     = (crc_q == 32'hC704DD7B);
  assign frm_ok     = crc_ok & ~trunc_q & (byte_cnt_q >= MIN_L);
  assign crc_base   = idle_like ? 32'hFFFFFFFF : crc_q;
  assign crc_d      = rx_v ? crc8(crc_base, bus.rx_data) : crc_base;

  // Commit-with-truncation and a rejected frame start can land in the same cycle.
  always_comb begin
    drop_inc = 2'd0;
    if (idle_like && rx_v && (bus.rx_last || start_full)) drop_inc = drop_inc + 2'd1;
    if (state_q == S_COMMIT && trunc_q) drop_inc = drop_inc + 2'd1;
    if (state_q == S_HDR && rx_v &&
        (bus.rx_last || (CTRL_DROP && byte_cnt_q == 11'd5 && ctrl_now)))
      drop_inc = drop_inc + 2'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      hdr_q       <= '0;
      is_ctrl_q   <= 1'b0;
      trunc_q     <= 1'b0;
      crc_q       <= 32'hFFFFFFFF;
      h_din_q     <= '0;
      h_wren_q    <= 1'b0;
      b_din_q     <= '0;
      b_del_q     <= 1'b0;
      b_wren_q    <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      h_wren_q    <= 1'b0;
      b_wren_q    <= 1'b0;
      b_del_q     <= 1'b0;
      crc_q       <= crc_d;
      drop_cnt_q  <= sat_add(drop_cnt_q, drop_inc);
      frame_cnt_q <= sat_add(frame_cnt_q, {1'b0, state_q == S_COMMIT});
      if (rx_v) byte_cnt_q <= cnt_inc;
      case (state_q)
        S_IDLE, S_COMMIT: begin
          if (state_q == S_COMMIT) begin
            h_wren_q <= 1'b1;
            h_din_q  <= {12'h000, frm_ok, is_ctrl_q, PORT_ID, hdr_q};
          end
          state_q <= S_IDLE;
          if (rx_v) begin
            byte_cnt_q <= 11'd1;
            trunc_q    <= 1'b0;
            hdr_q      <= {hdr_q[103:0], bus.rx_data};
            if (bus.rx_last)     state_q <= S_IDLE;
            else if (start_full) state_q <= S_DISCARD;
            else                 state_q <= S_HDR;
          end
        end
        // Every HDR byte has byte_cnt<=13, so rx_last here is always a runt.
        S_HDR: if (rx_v) begin
          hdr_q <= {hdr_q[103:0], bus.rx_data};
          if (byte_cnt_q == 11'd5) is_ctrl_q <= ctrl_now;
          if (bus.rx_last)                                        state_q <= S_IDLE;
          else if (CTRL_DROP && byte_cnt_q == 11'd5 && ctrl_now) state_q <= S_DISCARD;
          else if (byte_cnt_q == 11'd13)                         state_q <= S_BODY;
        end
        S_BODY: if (rx_v) begin
          b_wren_q <= 1'b1;
          b_din_q  <= bus.rx_data;
          if (bus.rx_last) begin
            b_del_q <= 1'b1;
            state_q <= S_COMMIT;
          end else if (bus.b_fifo_afull || cnt_inc == MAX_L) begin
            b_del_q <= 1'b1;
            trunc_q <= 1'b1;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN:   if (rx_v && bus.rx_last) state_q <= S_COMMIT;
        S_DISCARD: if (rx_v && bus.rx_last) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.h_fifo_din    = h_din_q;
  assign bus.h_fifo_wren   = h_wren_q;
  assign bus.b_fifo_din    = b_din_q;
  assign bus.b_fifo_del_in = b_del_q;
  assign bus.b_fifo_wren   = b_wren_q;
  assign rx_frame_cnt      = frame_cnt_q;
  assign rx_drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench: two parsers (CTRL_DROP=0 and 1) share one RX stream; the
// CTRL_DROP=0 instance is checked write-by-write against an Ethernet reference model.
module tb_rx_frame_parser;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  rx_frame_parser_if bus0();
  rx_frame_parser_if bus1();
  logic [15:0] fcnt0, dcnt0, fcnt1, dcnt1;

  rx_frame_parser #(.PORT_ID(2'd0), .MIN_LEN(64), .MAX_LEN(1518), .CTRL_DROP(1'b0)) u_dut (
    .clk(clk), .arst_n(arst_n), .bus(bus0.slave), .rx_frame_cnt(fcnt0), .rx_drop_cnt(dcnt0));
  rx_frame_parser #(.PORT_ID(2'd0), .MIN_LEN(64), .MAX_LEN(1518), .CTRL_DROP(1'b1)) u_drop (
    .clk(clk), .arst_n(arst_n), .bus(bus1.slave), .rx_frame_cnt(fcnt1), .rx_drop_cnt(dcnt1));

  assign bus1.rx_valid     = bus0.rx_valid;
  assign bus1.rx_data      = bus0.rx_data;
  assign bus1.rx_last      = bus0.rx_last;
  assign bus1.h_fifo_full  = bus0.h_fifo_full;
  assign bus1.b_fifo_afull = bus0.b_fifo_afull;

  typedef struct packed { logic [7:0] d; logic del; } bexp_t;
  bexp_t        exp_b[$];
  logic [127:0] exp_h[$];
  logic [7:0]   frm[$];
  int n_chk = 0, n_err = 0;
  int exp_frames = 0, exp_drops = 0;
  int b1_wr = 0, h1_wr = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                       input int plen, input bit bad);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
    frm.push_back(typ[15:8]);
    frm.push_back(typ[7:0]);
    for (int i = 0; i < plen; i++) frm.push_back(8'(i * 7 + 3));
    c = 32'hFFFFFFFF;
    foreach (frm[k]) c = crc_step(c, frm[k]);
    c = ~c;
    frm.push_back(c[7:0] ^ {7'd0, bad});
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  // Push the expected writes for frm, then drive it; stop_at>0 sends only that many bytes.
  task automatic send(input int gap_max, input int afull_at, input int stop_at);
    int n, lim;
    logic [111:0] h;
    logic [31:0] c;
    logic vld, trunc, done;
    bexp_t e;
    n = frm.size();
    lim = (stop_at > 0) ? stop_at : n;
    h = '0; c = 32'hFFFFFFFF; trunc = 1'b0; done = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = crc_step(c, frm[i]);
      if (i < 14) h = {h[103:0], frm[i]};
    end
    if (n > 14)
      for (int i = 14; i < lim && !done; i++) begin
        e.d = frm[i];
        e.del = (i == n - 1);
        if (!e.del && ((afull_at > 0 && i - 13 == afull_at) || i + 1 == 1518)) begin
          e.del = 1'b1; trunc = 1'b1; done = 1'b1;
        end else if (e.del) done = 1'b1;
        exp_b.push_back(e);
      end
    if (stop_at == 0) begin
      if (n <= 14) exp_drops++;
      else begin
        vld = (c == 32'hDEBB20E3) && !trunc && (n >= 64);
        exp_h.push_back({12'h000, vld, h[111:68] == 44'h0180C200000, 2'd0, h});
        exp_frames++;
        if (trunc) exp_drops++;
      end
    end
    for (int i = 0; i < lim; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        bus0.rx_valid = 1'b0;
        bus0.rx_last  = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
      end
      bus0.rx_valid = 1'b1;
      bus0.rx_data  = frm[i];
      bus0.rx_last  = (i == n - 1);
      if (afull_at > 0 && i - 13 == afull_at) bus0.b_fifo_afull = 1'b1;
      @(posedge clk); #1;
    end
    bus0.rx_valid = 1'b0;
    bus0.rx_last = 1'b0;
    bus0.b_fifo_afull = 1'b0;
  endtask

  task automatic settle(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_frame_cnt"}, fcnt0, exp_frames);
    chk({tag, "_drop_cnt"}, dcnt0, exp_drops);
    chk({tag, "_body_left"}, exp_b.size(), 0);
    chk({tag, "_hdr_left"}, exp_h.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_b_wren"}, bus0.b_fifo_wren, 0);
    chk({tag, "_b_din"}, {bus0.b_fifo_din, bus0.b_fifo_del_in}, 0);
    chk({tag, "_h_wren"}, bus0.h_fifo_wren, 0);
    chk({tag, "_h_din"}, bus0.h_fifo_din, 0);
    chk({tag, "_cnts"}, {fcnt0, dcnt0}, 0);
  endtask

  always @(negedge clk) begin
    if (bus0.b_fifo_wren) begin
      if (exp_b.size() == 0) chk("body_unexpected", exp_b.size(), 1);
      else begin
        bexp_t e;
        e = exp_b.pop_front();
        chk("body", {bus0.b_fifo_din, bus0.b_fifo_del_in}, {e.d, e.del});
      end
    end
    if (bus0.h_fifo_wren) begin
      if (exp_h.size() == 0) chk("hdr_unexpected", exp_h.size(), 1);
      else chk("hdr", bus0.h_fifo_din, exp_h.pop_front());
    end
    if (bus1.b_fifo_wren) b1_wr++;
    if (bus1.h_fifo_wren) h1_wr++;
  end

  localparam logic [47:0] DST = 48'h001122334455;
  localparam logic [47:0] SRC = 48'h66778899AABB;

  initial begin
    int b1, h1, d1;
    bus0.rx_valid = 1'b0; bus0.rx_data = '0; bus0.rx_last = 1'b0;
    bus0.h_fifo_full = 1'b0; bus0.b_fifo_afull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    arst_n = 1'b1;
    @(posedge clk); #1;

    build(DST, SRC, 16'h0800, 46, 1'b0);
    send(0, 0, 0);
    settle("good64");

    build(DST, SRC, 16'h0800, 46, 1'b1);
    send(0, 0, 0);
    settle("badfcs");

    b1 = b1_wr; h1 = h1_wr; d1 = int'(dcnt1);
    build(48'h0180C2000001, SRC, 16'h8808, 46, 1'b0);
    send(1, 0, 0);
    settle("ctrl");
    chk("ctrl_drop_bwr", b1_wr - b1, 0);
    chk("ctrl_drop_hwr", h1_wr - h1, 0);
    chk("ctrl_drop_cnt", int'(dcnt1) - d1, 1);

    build(DST, SRC, 16'h0800, 182, 1'b0);
    send(0, 20, 0);
    settle("afull");

    frm.delete();
    for (int i = 0; i < 10; i++) frm.push_back(8'(8'hA0 + i));
    send(0, 0, 0);
    build(DST, SRC, 16'h0800, 42, 1'b0);
    send(0, 0, 0);
    settle("runt_short");

    frm.delete();
    frm.push_back(8'h5A);
    send(0, 0, 0);
    settle("one_byte");

    build(DST, SRC, 16'h0800, 46, 1'b0);
    send(0, 0, 0);
    build(SRC, DST, 16'h86DD, 46, 1'b0);
    send(0, 0, 0);
    settle("b2b");

    for (int k = 0; k < 2; k++) begin
      build(DST ^ 48'(k), SRC, 16'h0800, 46 + 13 * k, 1'b0);
      send(3, 0, 0);
    end
    settle("gaps");

    build(DST, SRC, 16'h0800, 100, 1'b0);
    send(0, 0, 30);
    @(negedge clk);
    #1 arst_n = 1'b0;
    #1;
    chk_zero("midreset");
    chk("midreset_body_left", exp_b.size(), 0);
    exp_b.delete();
    exp_h.delete();
    exp_frames = 0;
    exp_drops = 0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    @(posedge clk); #1;
    build(DST, SRC, 16'h0800, 46, 1'b0);
    send(2, 0, 0);
    settle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
